eqchk_response_checker: RTL
===========================

Name: eqchk_response_checker

Overview:
- Receiving end of the equivalence-checking simulation flow. Each stimulus cycle applies one input vector to both the golden design and the synthesized `top`, and each produces a wide `y` word.
- This block consumes both `y` streams cycle by cycle and compares them. It counts mismatches, latches the first failing vector, and compacts the DUT stream into a MISR signature.
- Sits beside the DUT instances inside the bench/harness. It replaces per-cycle `$strobe` dumps with a synthesizable pass/fail verdict.

Parameters:
- WIDTH, 569, width of each compared `y` word.
- NUM_VEC, 20, vectors per run; legal range 1..2**CNT_W-1.
- CNT_W, 16, width of vector index and mismatch counter.
- SIG_W, 32, MISR width.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, MISR value loaded on start.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins or restarts a run.
- valid  in  1  `y_ref`/`y_dut` carry a vector this cycle.
- y_ref  in  WIDTH  golden-model output.
- y_dut  in  WIDTH  synthesized-netlist output.
- busy  out  1  state is RUN.
- done  out  1  run complete; held until start or rst.
- pass  out  1  done with zero mismatches; 0 whenever done=0.
- vec_cnt  out  CNT_W  vectors accepted this run.
- mismatch_cnt  out  CNT_W  mismatching vectors; saturates at all-ones.
- first_fail_idx  out  CNT_W  index of first mismatching vector; all-ones = none.
- first_fail_syn  out  SIG_W  XOR syndrome (`y_ref^y_dut`) of the first failure, folded to SIG_W.
- signature  out  SIG_W  MISR over all accepted `y_dut` words.

Behaviour:
- Reset values: state IDLE; busy, done, pass 0; vec_cnt, mismatch_cnt 0; first_fail_idx all-ones; first_fail_syn 0; signature SEED.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start -> RUN.
  - RUN: accepting vector index NUM_VEC-1 -> DONE.
  - DONE: start -> RUN.
- Start (any state): on the start edge, all counters, first_fail_* and signature return to reset values, then state becomes RUN. A start during RUN aborts and restarts.
- Accept: `valid && state==RUN`. valid is ignored in IDLE and DONE.
- Start and valid in the same cycle: start wins; that vector is dropped.
- Per accepted vector, at the same edge:
  - vec_cnt increments.
  - `mis = (y_ref != y_dut)`.
  - If mis: mismatch_cnt increments, saturating.
  - If mis and first_fail_idx is all-ones: first_fail_idx <= vec_cnt (pre-increment value) and first_fail_syn <= fold(y_ref^y_dut).
- fold(x): zero-pad x to a multiple of SIG_W, then XOR all SIG_W chunks; chunk 0 = bits [SIG_W-1:0].
- MISR update: `signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ fold(y_dut)`.
- Latency: outputs reflect a vector one cycle after its accept edge. done and pass rise in the cycle after the last accept edge; `pass = done && mismatch_cnt==0`.
- Reset mid-run: everything returns to reset values and the partial run is discarded.
- There is no back-pressure: every valid cycle in RUN is consumed.

Optional Feature:
- Macro: EQCHK_STOP_ON_FAIL_EN.
- Defined: the first mismatch moves RUN -> DONE at that same edge. vec_cnt then equals first_fail_idx+1, mismatch_cnt is 1, and pass is 0.
- Undefined: the run always consumes NUM_VEC vectors.

Decomposition:
- Package eqchk_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - default POLY and SEED constants;
  - the fold function, parameterized by WIDTH and SIG_W.
- One sub-module, eqchk_misr: holds the signature register and its seed load and update, with ports clk, rst, load, en, din[SIG_W].
- The parent owns the FSM, counters, compare and first-fail capture.

Test Plan:
- NUM_VEC=4, 4 valid vectors with `y_dut==y_ref`, values 0, 1, all-ones, 569'h1<<568 -> done=1, pass=1, vec_cnt=4, mismatch_cnt=0, first_fail_idx=16'hFFFF, signature equals the bench model.
- NUM_VEC=4, vector 2 has `y_dut = y_ref^1` -> mismatch_cnt=1, first_fail_idx=2, first_fail_syn=32'h1, pass=0.
- Vectors 1 and 3 mismatch with bit 40 flipped -> mismatch_cnt=2, first_fail_idx=1, first_fail_syn=32'h100 (bit 40 folds to bit 8).
- Start pulsed after 2 accepted vectors, then 4 clean vectors -> vec_cnt=4, counters restarted, signature covers only the last 4 vectors. Start asserted together with valid -> that vector is not counted.
- rst asserted for 1 cycle mid-run -> next cycle all outputs at reset values; valid pulses in IDLE leave vec_cnt=0.
- With EQCHK_STOP_ON_FAIL_EN defined, mismatch at index 1 of 20 -> done the next cycle, vec_cnt=2, mismatch_cnt=1, subsequent valid ignored.

Source files
------------

// File: rtl/eqchk_pkg.sv
// Shared types, default MISR constants and the XOR fold used by the
// equivalence-check response checker.
package eqchk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFF_FFFF;

  // fold() works on a fixed-size container; callers zero-extend into it
  localparam int unsigned FOLD_MAX_W     = 1024;
  localparam int unsigned FOLD_MAX_SIG_W = 64;
  localparam int unsigned FOLD_IDX_W     = $clog2(FOLD_MAX_W);
  localparam int unsigned FOLD_SIG_IDX_W = $clog2(FOLD_MAX_SIG_W);

  // XOR all sig_w-bit chunks of the low 'width' bits of x; bit i lands on bit i%sig_w
  function automatic logic [FOLD_MAX_SIG_W-1:0] fold(input logic [FOLD_MAX_W-1:0] x,
                                                     input int unsigned width,
                                                     input int unsigned sig_w);
    logic [FOLD_MAX_SIG_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FOLD_MAX_W; i++) begin
      if (i < width) begin
        r[FOLD_SIG_IDX_W'(i % sig_w)] = r[FOLD_SIG_IDX_W'(i % sig_w)] ^ x[FOLD_IDX_W'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/eqchk_misr.sv
// Multiple-input signature register: loads SEED on reset or load, shifts in din when en.
module eqchk_misr
  import eqchk_pkg::*;
#(
  parameter int unsigned          SIG_W = 32,
  parameter logic [SIG_W-1:0]     POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0]     SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] signature
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      signature <= SEED;
    end else if (en) begin
      signature <= {signature[SIG_W-2:0], 1'b0}
                 ^ (signature[SIG_W-1] ? POLY : '0)
                 ^ din;
    end
  end

endmodule

// File: rtl/eqchk_response_checker.sv
// Compares golden and DUT response streams, counts mismatches, captures the first
// failure and signs the DUT stream. Optional: EQCHK_STOP_ON_FAIL_EN ends the run on the first mismatch.
module eqchk_response_checker
  import eqchk_pkg::*;
#(
  parameter int unsigned      WIDTH   = 569,
  parameter int unsigned      NUM_VEC = 20,
  parameter int unsigned      CNT_W   = 16,
  parameter int unsigned      SIG_W   = 32,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] y_ref,
  input  logic [WIDTH-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [SIG_W-1:0] first_fail_syn,
  output logic [SIG_W-1:0] signature
);

  state_t           state;
  logic             accept;
  logic             mis;
  logic             last;
  logic             finish;
  logic [CNT_W-1:0] mis_cnt_nxt;
  logic [SIG_W-1:0] syn_fold;
  logic [SIG_W-1:0] dut_fold;

  // start has priority: a vector presented alongside start is dropped
  always_comb begin
    accept      = valid && (state == RUN) && !start;
    mis         = (y_ref != y_dut);
    last        = (vec_cnt == CNT_W'(NUM_VEC - 1));
    syn_fold    = SIG_W'(fold(FOLD_MAX_W'(y_ref ^ y_dut), WIDTH, SIG_W));
    dut_fold    = SIG_W'(fold(FOLD_MAX_W'(y_dut), WIDTH, SIG_W));
    mis_cnt_nxt = mismatch_cnt;
    if (accept && mis && (mismatch_cnt != '1)) begin
      mis_cnt_nxt = mismatch_cnt + CNT_W'(1);
    end
`ifdef EQCHK_STOP_ON_FAIL_EN
    finish = accept && (last || mis);
`else
    finish = accept && last;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      state          <= rst ? IDLE : RUN;
      busy           <= !rst;
      done           <= 1'b0;
      pass           <= 1'b0;
      vec_cnt        <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '1;
      first_fail_syn <= '0;
    end else if (accept) begin
      vec_cnt      <= vec_cnt + CNT_W'(1);
      mismatch_cnt <= mis_cnt_nxt;
      if (mis && (first_fail_idx == '1)) begin
        first_fail_idx <= vec_cnt;
        first_fail_syn <= syn_fold;
      end
      if (finish) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (mis_cnt_nxt == '0);
      end
    end
  end

  eqchk_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .load      (start),
    .en        (accept),
    .din       (dut_fold),
    .signature (signature)
  );

endmodule
